write_burst_master: RTL and testbench
=====================================

WRITE_BURST_MASTER -- requirements
Module: write_burst_master

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 48, byte address width.
REQ-002 Parameter DATA_WIDTH, default 512, data bus width in bits; DATA_WIDTH/8 is a power of 2.
REQ-003 Parameter BURST_WIDTH, default 3; MAX_BURST = 2^(BURST_WIDTH-1) beats.
REQ-004 Parameter LENGTH_WIDTH, default 20, command length width in beats.
REQ-005 Parameter MAX_PENDING_WIDTH, default 6; MAX_PENDING = 2^(MAX_PENDING_WIDTH-1) outstanding bursts.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  sole clock, all logic on rising edge.
REQ-008 reset_n  in  1  asynchronous active-low reset.
REQ-009 cmd_valid / cmd_ready  in/out  1 each  command handshake.
REQ-010 cmd_address  in  ADDRESS_WIDTH  start byte address, beat-aligned.
REQ-011 cmd_length  in  LENGTH_WIDTH  transfer length in beats.
REQ-012 snk_data  in  DATA_WIDTH  write data stream.
REQ-013 snk_valid / snk_ready  in/out  1 each  data stream handshake.
REQ-014 m_address, m_writedata, m_write, m_byteenable, m_burst  out  ADDRESS_WIDTH, DATA_WIDTH, 1, DATA_WIDTH/8, BURST_WIDTH  Avalon-MM burst write master.
REQ-015 m_waitrequest  in  1;  m_response  in  2;  m_write_response_valid  in  1.
REQ-016 busy  out  1  command in progress;  done  out  1  one-cycle completion pulse;  error  out  1  sticky error flag.

Function
REQ-017 FSM states IDLE, BURST, WAIT_RESP; cmd_ready = (state==IDLE).
REQ-018 Command accept (cmd_valid & cmd_ready): latch address, remaining=cmd_length, clear error; go BURST if length!=0, else stay IDLE and pulse done next cycle.
REQ-019 Burst size = min(remaining, MAX_BURST); m_address and m_burst held constant for all beats of a burst.
REQ-020 m_write = (state==BURST) & snk_valid & burst_may_start_or_in_progress; m_writedata = snk_data; m_byteenable all ones.
REQ-021 Beat accepted when m_write & ~m_waitrequest; snk_ready = same condition (combinational, no data buffering).
REQ-022 While m_waitrequest=1 all m_* outputs shall remain stable.
REQ-023 After last beat of a burst: address += burst*DATA_WIDTH/8 (modulo 2^ADDRESS_WIDTH), remaining -= burst; if remaining==0 go WAIT_RESP.
REQ-024 Pending counter (MAX_PENDING_WIDTH bits) increments on first accepted beat of each burst, decrements on m_write_response_valid; simultaneous inc and dec -> unchanged.
REQ-025 New burst shall not start (m_write=0 on first beat) while pending MSB set; a burst already started completes regardless.
REQ-026 Response valid with pending==0 ignored; counter never underflows.
REQ-027 error set when m_write_response_valid & m_response!=2'b00; held until next command accept.
REQ-028 WAIT_RESP -> IDLE when pending==0 after decrements; done pulses one cycle on that transition; busy = (state!=IDLE).
REQ-029 error valid no later than the done pulse it qualifies.

Reset
REQ-030 reset_n low: state=IDLE, pending=0, remaining=0, m_write=0, snk_ready=0, done=0, error=0, busy=0, cmd_ready=1 after release; address/data regs need no reset.
REQ-031 Reset mid-burst aborts immediately; no m_write asserted in the cycle after release.

Verification
REQ-032 cmd_address=0x1000, length=10, MAX_BURST=4, no stalls -> bursts 4,4,2 at 0x1000,0x1100,0x1200; done one cycle after 3rd response.
REQ-033 length=0 -> no m_write, done=1 for exactly one cycle, cmd_ready=1 again.
REQ-034 m_waitrequest held 5 cycles mid-burst -> m_address/m_writedata/m_burst unchanged, no beat lost or duplicated, snk_ready=0 throughout.
REQ-035 m_response=2'b10 on 2nd of 3 responses -> error=1 with done, cleared on next command accept.
REQ-036 Responses withheld, length=4*40 -> exactly 32 bursts issued then m_write=0; one response -> exactly one more burst starts.
REQ-037 reset_n asserted on beat 2 of a 4-beat burst -> all outputs at reset values asynchronously; fresh command afterwards completes normally.

Source files
------------

// File: rtl/write_burst_master.sv
// write_burst_master: turns a (start address, length in beats) command into a
// sequence of Avalon-MM write bursts of at most MAX_BURST beats each. Write
// data passes straight from the sink stream to the master port with no
// buffering. The number of bursts still awaiting a write response is bounded.
module write_burst_master #(
    parameter int ADDRESS_WIDTH     = 48,
    parameter int DATA_WIDTH        = 512,
    parameter int BURST_WIDTH       = 3,
    parameter int LENGTH_WIDTH      = 20,
    parameter int MAX_PENDING_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_address,
    input  logic [LENGTH_WIDTH-1:0]   cmd_length,
    input  logic [DATA_WIDTH-1:0]     snk_data,
    input  logic                      snk_valid,
    output logic                      snk_ready,
    output logic [ADDRESS_WIDTH-1:0]  m_address,
    output logic [DATA_WIDTH-1:0]     m_writedata,
    output logic                      m_write,
    output logic [DATA_WIDTH/8-1:0]   m_byteenable,
    output logic [BURST_WIDTH-1:0]    m_burst,
    input  logic                      m_waitrequest,
    input  logic [1:0]                m_response,
    input  logic                      m_write_response_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam logic [LENGTH_WIDTH-1:0] MAX_BURST_LEN = LENGTH_WIDTH'(2 ** (BURST_WIDTH - 1));
    localparam logic [BURST_WIDTH-1:0]  MAX_BURST_BT  = BURST_WIDTH'(2 ** (BURST_WIDTH - 1));

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BURST     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t                       state_r;
    state_t                       state_next_s;
    logic [ADDRESS_WIDTH-1:0]     address_r;
    logic [LENGTH_WIDTH-1:0]      remaining_r;
    logic [BURST_WIDTH-1:0]       beat_cnt_r;
    logic [MAX_PENDING_WIDTH-1:0] pending_r;
    logic [MAX_PENDING_WIDTH-1:0] pending_next_s;
    logic                         error_r;
    logic                         done_r;

    logic [BURST_WIDTH-1:0]       burst_size_s;
    logic [ADDRESS_WIDTH-1:0]     burst_bytes_s;
    logic                         cmd_accept_s;
    logic                         may_issue_s;
    logic                         beat_s;
    logic                         first_beat_s;
    logic                         last_beat_s;
    logic                         resp_dec_s;
    logic                         resp_err_s;

    // Size of the current burst: whatever is left, capped at MAX_BURST.
    // remaining_r only changes at a burst boundary, so this is stable per burst.
    always_comb begin
        if (remaining_r >= MAX_BURST_LEN) begin
            burst_size_s = MAX_BURST_BT;
        end else begin
            burst_size_s = remaining_r[BURST_WIDTH-1:0];
        end
    end

    // Beat/handshake qualifiers. A burst that has already begun always finishes;
    // only its first beat is held back when the outstanding-burst limit is hit.
    always_comb begin
        burst_bytes_s = ADDRESS_WIDTH'(burst_size_s) << BYTE_SHIFT;
        cmd_accept_s  = cmd_valid & cmd_ready;
        may_issue_s   = (beat_cnt_r != BURST_WIDTH'(0)) | ~pending_r[MAX_PENDING_WIDTH-1];
        beat_s        = m_write & ~m_waitrequest;
        first_beat_s  = beat_s & (beat_cnt_r == BURST_WIDTH'(0));
        last_beat_s   = beat_s & (beat_cnt_r == (burst_size_s - BURST_WIDTH'(1)));
        resp_dec_s    = m_write_response_valid & (pending_r != MAX_PENDING_WIDTH'(0));
        resp_err_s    = m_write_response_valid & (m_response != 2'b00);
    end

    // Outstanding-burst count: +1 on each burst's first beat, -1 per response,
    // responses arriving with nothing outstanding are dropped.
    always_comb begin
        case ({first_beat_s, resp_dec_s})
            2'b10:   pending_next_s = pending_r + MAX_PENDING_WIDTH'(1);
            2'b01:   pending_next_s = pending_r - MAX_PENDING_WIDTH'(1);
            default: pending_next_s = pending_r;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_accept_s && (cmd_length != LENGTH_WIDTH'(0))) begin
                    state_next_s = BURST;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BURST: begin
                if (last_beat_s && (remaining_r == LENGTH_WIDTH'(burst_size_s))) begin
                    state_next_s = WAIT_RESP;
                end else begin
                    state_next_s = BURST;
                end
            end
            WAIT_RESP: begin
                if (pending_next_s == MAX_PENDING_WIDTH'(0)) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs; m_write and snk_ready are combinational so data needs no buffer.
    always_comb begin
        cmd_ready = (state_r == IDLE);
        busy      = (state_r != IDLE);
        m_write   = (state_r == BURST) & snk_valid & may_issue_s;
        snk_ready = m_write & ~m_waitrequest;
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining_r <= LENGTH_WIDTH'(0);
            beat_cnt_r  <= BURST_WIDTH'(0);
            pending_r   <= MAX_PENDING_WIDTH'(0);
            error_r     <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            pending_r <= pending_next_s;
            done_r    <= (cmd_accept_s & (cmd_length == LENGTH_WIDTH'(0)))
                       | ((state_r == WAIT_RESP) & (state_next_s == IDLE));
            if (cmd_accept_s) begin
                remaining_r <= cmd_length;
                beat_cnt_r  <= BURST_WIDTH'(0);
                error_r     <= 1'b0;
            end else begin
                if (resp_err_s) begin
                    error_r <= 1'b1;
                end else begin
                    error_r <= error_r;
                end
                if (last_beat_s) begin
                    remaining_r <= remaining_r - LENGTH_WIDTH'(burst_size_s);
                    beat_cnt_r  <= BURST_WIDTH'(0);
                end else if (beat_s) begin
                    beat_cnt_r  <= beat_cnt_r + BURST_WIDTH'(1);
                end else begin
                    beat_cnt_r  <= beat_cnt_r;
                end
            end
        end
    end

    // Burst address register; needs no reset because it is loaded on every accept.
    always_ff @(posedge clk) begin
        if (cmd_accept_s) begin
            address_r <= cmd_address;
        end else if (last_beat_s) begin
            address_r <= address_r + burst_bytes_s;
        end else begin
            address_r <= address_r;
        end
    end

    assign m_address    = address_r;
    assign m_burst      = burst_size_s;
    assign m_writedata  = snk_data;
    assign m_byteenable = {BYTES{1'b1}};
    assign done         = done_r;
    assign error        = error_r;

endmodule

// File: tb/tb_write_burst_master.sv
// Bench for write_burst_master: directed commands, a transaction-level model
// (expected beat list per command, outstanding-burst count, done/busy/error)
// checked every cycle, plus literal expectations for the key scenarios.
module tb_write_burst_master;

    localparam int AW   = 48;
    localparam int DW   = 512;
    localparam int BW   = 3;
    localparam int LW   = 20;
    localparam int PW   = 6;
    localparam int MAXB = 4;
    localparam int MAXP = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [AW-1:0]   cmd_address;
    logic [LW-1:0]   cmd_length;
    logic [DW-1:0]   snk_data;
    logic            snk_valid;
    logic            snk_ready;
    logic [AW-1:0]   m_address;
    logic [DW-1:0]   m_writedata;
    logic            m_write;
    logic [DW/8-1:0] m_byteenable;
    logic [BW-1:0]   m_burst;
    logic            m_waitrequest;
    logic [1:0]      m_response;
    logic            m_write_response_valid;
    logic            busy;
    logic            done;
    logic            error;

    write_burst_master #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW),
        .LENGTH_WIDTH(LW), .MAX_PENDING_WIDTH(PW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_address(cmd_address), .cmd_length(cmd_length),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .m_address(m_address), .m_writedata(m_writedata), .m_write(m_write),
        .m_byteenable(m_byteenable), .m_burst(m_burst),
        .m_waitrequest(m_waitrequest), .m_response(m_response),
        .m_write_response_valid(m_write_response_valid),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act[63:0], exp[63:0]);
    endtask

    // Data word carried by the k-th beat of the sink stream.
    function automatic logic [DW-1:0] pat(input int k);
        logic [31:0] w;
        w = (32'(k) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        return {(DW/32){w}};
    endfunction

    // ---------------- sink stream source ----------------
    int src_idx = 0;
    initial begin
        logic took;
        snk_data = pat(0);
        forever begin
            @(negedge clk);
            took = snk_valid & snk_ready;
            @(posedge clk);
            #1;
            if (took) begin
                src_idx++;
                snk_data = pat(src_idx);
            end
        end
    end

    // ---------------- transaction model and per-cycle compare ----------------
    typedef struct {
        logic [AW-1:0] addr;
        int            burst;
        bit            first;
    } beat_t;

    beat_t         exp_q[$];
    logic [AW-1:0] start_addr[$];
    int            start_burst[$];
    int            outstanding = 0;
    int            beats_seen  = 0;
    int            chk_idx     = 0;
    bit            busy_m = 1'b0, done_m = 1'b0, err_m = 1'b0;
    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [BW-1:0] prev_burst;
    logic [DW-1:0] prev_data;

    initial begin
        beat_t         e;
        bit            new_first;
        logic [AW-1:0] a;
        int            rem, b;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_q.delete();
                outstanding = 0;
                busy_m = 1'b0; done_m = 1'b0; err_m = 1'b0; prev_stall = 1'b0;
            end else begin
                chk1("done", done, done_m);
                chk1("busy", busy, busy_m);
                chk1("cmd_ready", cmd_ready, !busy_m);
                chk1("error", error, err_m);
                chk1("snk_ready", snk_ready, m_write & !m_waitrequest);
                if (prev_stall) begin
                    chk1("stall_write", m_write, 1'b1);
                    chk("stall_addr", 64'(m_address), 64'(prev_addr));
                    chk("stall_burst", 64'(m_burst), 64'(prev_burst));
                    chk_data("stall_data", m_writedata, prev_data);
                end
                done_m    = 1'b0;
                new_first = 1'b0;
                if (m_write && !m_waitrequest) begin
                    chk1("beat_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("beat_addr", 64'(m_address), 64'(e.addr));
                        chk("beat_burst", 64'(m_burst), 64'(e.burst));
                        chk_data("beat_data", m_writedata, pat(chk_idx));
                        chk1("byteenable", &m_byteenable, 1'b1);
                        if (e.first) begin
                            chk1("pend_limit", outstanding < MAXP, 1'b1);
                            start_addr.push_back(m_address);
                            start_burst.push_back(int'(m_burst));
                            new_first = 1'b1;
                        end
                    end
                    chk_idx++;
                    beats_seen++;
                end
                if (m_write_response_valid && outstanding > 0) outstanding--;
                if (new_first) outstanding++;
                if (m_write_response_valid && m_response != 2'b00) err_m = 1'b1;
                if (cmd_valid && !busy_m) begin
                    err_m = 1'b0;
                    if (cmd_length == '0) begin
                        done_m = 1'b1;
                    end else begin
                        busy_m = 1'b1;
                        a   = cmd_address;
                        rem = int'(cmd_length);
                        while (rem > 0) begin
                            b = (rem < MAXB) ? rem : MAXB;
                            for (int i = 0; i < b; i++) begin
                                e.addr = a; e.burst = b; e.first = (i == 0);
                                exp_q.push_back(e);
                            end
                            a   = a + AW'(b * (DW / 8));
                            rem = rem - b;
                        end
                    end
                end else if (busy_m && exp_q.size() == 0 && outstanding == 0) begin
                    busy_m = 1'b0;
                    done_m = 1'b1;
                end
                prev_stall = m_write && m_waitrequest;
                prev_addr  = m_address;
                prev_burst = m_burst;
                prev_data  = m_writedata;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [AW-1:0] a, input logic [LW-1:0] l);
        int t;
        t = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_address = a; cmd_length = l;
        while (!cmd_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk1("cmd_accept", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_resp(input logic [1:0] code);
        @(posedge clk); #1;
        m_write_response_valid = 1'b1; m_response = code;
        @(posedge clk); #1;
        m_write_response_valid = 1'b0; m_response = 2'b00;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int t;
        t = 0;
        while (beats_seen < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk1("wait_beats", beats_seen >= n, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int bs, bb;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_address = '0; cmd_length = '0;
        snk_valid = 1'b1; m_waitrequest = 1'b0; m_response = 2'b00;
        m_write_response_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk1("rst_cmd_ready", cmd_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_error", error, 1'b0);
        chk1("rst_m_write", m_write, 1'b0);
        chk1("rst_snk_ready", snk_ready, 1'b0);

        // 10 beats from 0x1000 -> bursts 4,4,2
        bs = start_addr.size(); bb = beats_seen;
        issue(48'h1000, 20'd10);
        wait_beats(bb + 10, 40);
        repeat (3) @(negedge clk);
        chk1("t1_idle_write", m_write, 1'b0);
        chk("t1_nbursts", 64'(start_addr.size() - bs), 64'd3);
        chk("t1_a0", 64'(start_addr[bs]),     64'h1000);
        chk("t1_a1", 64'(start_addr[bs + 1]), 64'h1100);
        chk("t1_a2", 64'(start_addr[bs + 2]), 64'h1200);
        chk("t1_b0", 64'(start_burst[bs]),     64'd4);
        chk("t1_b1", 64'(start_burst[bs + 1]), 64'd4);
        chk("t1_b2", 64'(start_burst[bs + 2]), 64'd2);
        send_resp(2'b00);
        send_resp(2'b00);
        chk1("t1_busy_before_last", busy, 1'b1);
        send_resp(2'b00);
        chk1("t1_done", done, 1'b1);
        @(posedge clk); #1;
        chk1("t1_done_clear", done, 1'b0);
        chk1("t1_ready", cmd_ready, 1'b1);

        // zero length
        bb = beats_seen;
        issue(48'h5000, 20'd0);
        chk1("t2_done", done, 1'b1);
        chk1("t2_busy", busy, 1'b0);
        @(posedge clk); #1;
        chk1("t2_done_clear", done, 1'b0);
        chk1("t2_ready", cmd_ready, 1'b1);
        repeat (3) @(posedge clk);
        chk("t2_no_beats", 64'(beats_seen - bb), 64'd0);

        // waitrequest held 5 cycles mid-burst
        bb = beats_seen;
        issue(48'h2000, 20'd4);
        wait_beats(bb + 2, 20);
        @(posedge clk); #1;
        m_waitrequest = 1'b1;
        repeat (2) @(posedge clk);
        chk1("t3_stall_snk_ready", snk_ready, 1'b0);
        chk("t3_stall_addr", 64'(m_address), 64'h2000);
        chk_data("t3_stall_data", m_writedata, pat(chk_idx));
        repeat (3) @(posedge clk);
        #1 m_waitrequest = 1'b0;
        wait_beats(bb + 4, 20);
        repeat (3) @(negedge clk);
        chk("t3_beats", 64'(beats_seen - bb), 64'd4);
        send_resp(2'b00);
        chk1("t3_done", done, 1'b1);

        // error response on the 2nd of 3
        bb = beats_seen;
        issue(48'h6000, 20'd12);
        wait_beats(bb + 12, 40);
        repeat (2) @(negedge clk);
        send_resp(2'b00);
        chk1("t4_err_before", error, 1'b0);
        send_resp(2'b10);
        chk1("t4_err_set", error, 1'b1);
        send_resp(2'b00);
        chk1("t4_done", done, 1'b1);
        chk1("t4_err_with_done", error, 1'b1);
        issue(48'h7000, 20'd0);
        chk1("t4_err_cleared", error, 1'b0);

        // outstanding limit: 160 beats, responses withheld
        bs = start_addr.size();
        issue(48'h10000, 20'd160);
        repeat (200) @(negedge clk);
        chk("t5_bursts_32", 64'(start_addr.size() - bs), 64'd32);
        chk1("t5_blocked", m_write, 1'b0);
        chk("t5_last_addr", 64'(start_addr[start_addr.size() - 1]), 64'h10000 + 64'd31 * 64'd256);
        send_resp(2'b00);
        repeat (10) @(negedge clk);
        chk("t5_bursts_33", 64'(start_addr.size() - bs), 64'd33);
        chk1("t5_blocked_again", m_write, 1'b0);
        for (int i = 0; i < 38; i++) begin
            send_resp(2'b00);
            repeat (5) @(posedge clk);
        end
        chk("t5_bursts_40", 64'(start_addr.size() - bs), 64'd40);
        send_resp(2'b00);
        chk1("t5_done", done, 1'b1);

        // asynchronous reset in the middle of a 4-beat burst
        bb = beats_seen;
        issue(48'h3000, 20'd4);
        wait_beats(bb + 1, 20);
        @(posedge clk); #1;
        chk1("t6_mid_burst", m_write, 1'b1);
        reset_n = 1'b0;
        #1;
        chk1("t6_rst_m_write", m_write, 1'b0);
        chk1("t6_rst_snk_ready", snk_ready, 1'b0);
        chk1("t6_rst_busy", busy, 1'b0);
        chk1("t6_rst_cmd_ready", cmd_ready, 1'b1);
        chk1("t6_rst_done", done, 1'b0);
        chk1("t6_rst_error", error, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk1("t6_no_write_after", m_write, 1'b0);
        bs = start_addr.size(); bb = beats_seen;
        issue(48'h4000, 20'd6);
        wait_beats(bb + 6, 30);
        repeat (2) @(negedge clk);
        chk("t6_nbursts", 64'(start_addr.size() - bs), 64'd2);
        chk("t6_a1", 64'(start_addr[bs + 1]), 64'h4100);
        chk("t6_b1", 64'(start_burst[bs + 1]), 64'd2);
        send_resp(2'b00);
        send_resp(2'b00);
        chk1("t6_done", done, 1'b1);

        repeat (3) @(negedge clk);
        chk("expq_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
